jp_poll: RTL and testbench
==========================

# jp_poll

Serial joypad front end for the two NES controller ports, sitting between the board-level joypad pins (`NES_JOYPAD_*`) and the CPU register interface inside the rp2a03. It periodically latches and clocks both 4021-style pads, keeps a debounced 8-bit button image per pad, and presents $4016/$4017 to the CPU with standard strobe/shift-register read semantics. CPU reads never wait on the serial bus.

## Interface
Parameters:
- `POLL_DIV`, 1666666: clocks between poll starts (60 Hz at 100 MHz).
- `HALF_PERIOD`, 600: clocks per half bit-period on `jp_clk`/`jp_latch` (6 us at 100 MHz); must be ≥2.

Ports:
- `clk_in`  in  1  system clock (100 MHz domain).
- `nres_in`  in  1  reset, synchronous, active-low.
- `jp_data1_in`  in  1  pad 1 serial data, active-low (0 = pressed).
- `jp_data2_in`  in  1  pad 2 serial data, active-low.
- `jp_clk`  out  1  pad shift clock, shared by both pads.
- `jp_latch`  out  1  pad parallel-load strobe, shared by both pads.
- `cs_in`  in  1  one-cycle access pulse for $4016/$4017.
- `a_in`  in  1  0 = $4016, 1 = $4017.
- `r_nw_in`  in  1  1 = read, 0 = write.
- `d_in`  in  8  CPU write data; only bit 0 is used.
- `d_out`  out  8  CPU read data. Zero when not reading, so it can be OR-merged onto the CPU data bus.

## Operation
- Button bit order in every image is bit0..7 = A, B, Select, Start, Up, Down, Left, Right. Internal polarity is 1 = pressed.
- Poll FSM states:
  - IDLE: counts `POLL_DIV` clocks, then goes to LATCH.
  - LATCH: `jp_latch`=1 for 2·`HALF_PERIOD` clocks.
  - CLK_HI: `jp_clk`=1 for `HALF_PERIOD` clocks.
  - CLK_LO: `jp_clk`=0 for `HALF_PERIOD` clocks.
- Sampling:
  - Bit 0 is sampled on the last LATCH cycle.
  - Bits 1..7 are each sampled on the last cycle of a CLK_HI→CLK_LO pair.
  - Sampled bits are inverted and shifted into two capture registers.
- After bit 7 is sampled, both capture registers are copied atomically to `pad1_state`/`pad2_state` on the next edge, and the FSM returns to IDLE with its counter cleared.
- Strobe register `strobe`: a write to $4016 sets `strobe` ← `d_in[0]`. Writes to $4017 are ignored.
- While `strobe`=1, shift registers `sh1`/`sh2` reload from `pad1_state`/`pad2_state` every cycle.
- When `strobe` goes 1→0, the reload from that cycle holds.
- Reads:
  - A read of $4016 returns `d_out` = {7'b0, `sh1[0]`}.
  - A read of $4017 returns `d_out` = {7'b0, `sh2[0]`}.
  - Both are combinational during the `cs_in` cycle.
- Shift-on-read:
  - If `strobe`=0, the read register shifts right at the end of the read cycle, filling with 1.
  - After 8 reads, every further read returns 1.
  - If `strobe`=1, reads do not shift and keep returning A.
- `d_out` = 0 whenever `cs_in`=0 or `r_nw_in`=0.

## Timing
- Reset values when `nres_in`=0 at an edge:
  - Outputs: `jp_clk`=0, `jp_latch`=0, `d_out`=0.
  - Internal state: FSM=IDLE, poll counter=0, capture/state registers=0, `sh1`/`sh2`=0, `strobe`=0.
- Reset asserted mid-poll aborts the poll immediately. Lines drop low on the next edge, and the state registers keep their reset value of 0.
- First `jp_latch` rise is `POLL_DIV` cycles after reset release.
- A full poll takes 16·`HALF_PERIOD` clocks of activity. The state update lands 1 cycle after the bit-7 sample.
- Poll period is `POLL_DIV` + 16·`HALF_PERIOD` + 1 clocks.
- Simultaneous state commit and strobe reload in the same cycle: the reload sees the old state. The new state is visible from the next cycle.
- Simultaneous write and read cannot occur, because there is one access per `cs_in` pulse.
- `d_out` read latency is 0 cycles (combinational). Shift takes effect on the following cycle.
- `jp_clk` and `jp_latch` are registered outputs, glitch-free, and never high simultaneously.

## Test plan
Bench uses `POLL_DIV`=100 and `HALF_PERIOD`=4.
- Reset, then idle → `jp_latch` rises at cycle 100 after reset release and stays high 8 cycles. It is followed by 7 `jp_clk` pulses, each 4 high / 4 low. `jp_clk` and `jp_latch` are never both 1.
- Pad model 1 drives buttons A+Start (active-low serial 0,1,1,0,1,1,1,1). Wait for the poll, write $4016=1 then $4016=0, then perform 10 reads of $4016 → returns 1,0,0,1,0,0,0,0,1,1.
- Pad 2 holds Left only. Strobe 1/0, then perform 8 reads of $4017 → returns 0,0,0,0,0,0,1,0. Pad 1 shift state is unaffected.
- Hold `strobe`=1 and read $4016 three times with A pressed → returns 1,1,1. After the pad changes to no buttons and the next poll completes, the next read returns 0.
- Assert `nres_in`=0 during CLK_HI of bit 4 → `jp_clk`=0 and `jp_latch`=0 on the next edge. After release, reads return 0 and the next latch occurs 100 cycles later.
- With `cs_in`=0, and during a $4016 write → `d_out`=8'h00 in every cycle.

Source files
------------

// File: rtl/jp_poll_if.sv
// CPU-side register port of the joypad front end ($4016/$4017 access).
// Handshake: cs_in is a one-cycle access strobe with no ready/wait; a read is
// answered combinationally in the same cycle, and a write takes effect at its edge.
interface jp_poll_if;
  logic       cs_in;
  logic       a_in;
  logic       r_nw_in;
  logic [7:0] d_in;
  logic [7:0] d_out;

  modport master (output cs_in, a_in, r_nw_in, d_in, input d_out);
  modport slave  (input cs_in, a_in, r_nw_in, d_in, output d_out);
endinterface

// File: rtl/jp_poll.sv
// Dual NES pad poller: periodic latch/clock of both 4021 pads, per-pad button
// image, and $4016/$4017 strobe + shift-register read semantics for the CPU.
module jp_poll #(
  parameter int POLL_DIV    = 1666666,
  parameter int HALF_PERIOD = 600
) (
  input  logic       clk_in,
  input  logic       nres_in,
  input  logic       jp_data1_in,
  input  logic       jp_data2_in,
  output logic       jp_clk,
  output logic       jp_latch,
  jp_poll_if.slave   bus,
  output logic [1:0] o_dbg_state
);

  localparam int CNT_MAX = (POLL_DIV > 2 * HALF_PERIOD) ? POLL_DIV : 2 * HALF_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] IDLE_LAST  = CW'(POLL_DIV - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * HALF_PERIOD - 1);
  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_PERIOD - 1);

  // Debug encoding on o_dbg_state: 0 IDLE, 1 LATCH, 2 CLK_HI, 3 CLK_LO.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LATCH  = 2'd1,
    S_CLK_HI = 2'd2,
    S_CLK_LO = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic          r_commit;
  logic [1:0]    r_sync1, r_sync2;
  logic [7:0]    r_cap1, r_cap2;
  logic [7:0]    r_pad1, r_pad2;
  logic          r_strobe;
  logic [7:0]    r_sh1, r_sh2;

  logic w_rd, w_rd1, w_rd2, w_wr0, w_d1, w_d2, w_unused_d;

  assign w_d1 = r_sync1[1];
  assign w_d2 = r_sync2[1];
  assign o_dbg_state = r_state;

  always_ff @(posedge clk_in) begin
    if (!nres_in) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_bit    <= 3'd0;
      r_commit <= 1'b0;
      r_sync1  <= 2'b11;
      r_sync2  <= 2'b11;
      r_cap1   <= 8'h00;
      r_cap2   <= 8'h00;
      r_pad1   <= 8'h00;
      r_pad2   <= 8'h00;
      jp_clk   <= 1'b0;
      jp_latch <= 1'b0;
    end else begin
      // Pad lines are asynchronous to clk_in; both settle long before sampling.
      r_sync1 <= {r_sync1[0], jp_data1_in};
      r_sync2 <= {r_sync2[0], jp_data2_in};
      case (r_state)
        S_IDLE: begin
          if (r_commit) begin
            r_pad1   <= r_cap1;
            r_pad2   <= r_cap2;
            r_commit <= 1'b0;
            r_cnt    <= '0;
          end else if (r_cnt == IDLE_LAST) begin
            r_state  <= S_LATCH;
            r_cnt    <= '0;
            jp_latch <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_LATCH: begin
          if (r_cnt == LATCH_LAST) begin
            r_cap1   <= {~w_d1, r_cap1[7:1]};
            r_cap2   <= {~w_d2, r_cap2[7:1]};
            r_bit    <= 3'd0;
            r_cnt    <= '0;
            r_state  <= S_CLK_HI;
            jp_latch <= 1'b0;
            jp_clk   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_CLK_HI: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt   <= '0;
            r_state <= S_CLK_LO;
            jp_clk  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          if (r_cnt == HALF_LAST) begin
            r_cap1 <= {~w_d1, r_cap1[7:1]};
            r_cap2 <= {~w_d2, r_cap2[7:1]};
            r_cnt  <= '0;
            if (r_bit == 3'd6) begin
              r_state  <= S_IDLE;
              r_commit <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_state <= S_CLK_HI;
              jp_clk  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign w_rd  = bus.cs_in & bus.r_nw_in;
  assign w_rd1 = w_rd & ~bus.a_in;
  assign w_rd2 = w_rd & bus.a_in;
  assign w_wr0 = bus.cs_in & ~bus.r_nw_in & ~bus.a_in;
  assign w_unused_d = ^bus.d_in[7:1];

  assign bus.d_out = w_rd ? {7'b0, (bus.a_in ? r_sh2[0] : r_sh1[0])} : 8'h00;

  // Reload uses the registered strobe, so the cycle that clears it still reloads.
  always_ff @(posedge clk_in) begin
    if (!nres_in) begin
      r_strobe <= 1'b0;
      r_sh1    <= 8'h00;
      r_sh2    <= 8'h00;
    end else begin
      if (w_wr0) r_strobe <= bus.d_in[0];
      if (r_strobe) begin
        r_sh1 <= r_pad1;
        r_sh2 <= r_pad2;
      end else begin
        if (w_rd1) r_sh1 <= {1'b1, r_sh1[7:1]};
        if (w_rd2) r_sh2 <= {1'b1, r_sh2[7:1]};
      end
    end
  end

endmodule

// File: tb/tb_jp_poll.sv
// Bench for jp_poll: 4021 pad models, poll timing checks, and CPU read
// sequences checked against a button-image model of the register semantics.
module tb_jp_poll;
  localparam int POLL_DIV    = 100;
  localparam int HALF_PERIOD = 4;
  localparam int POLL_DONE   = 16 * HALF_PERIOD + 2;

  logic       clk = 1'b0;
  logic       nres = 1'b0;
  logic       jp_data1, jp_data2, jp_clk, jp_latch;
  logic [1:0] dbg_state;

  jp_poll_if bus ();

  jp_poll #(.POLL_DIV(POLL_DIV), .HALF_PERIOD(HALF_PERIOD)) dut (
    .clk_in      (clk),
    .nres_in     (nres),
    .jp_data1_in (jp_data1),
    .jp_data2_in (jp_data2),
    .jp_clk      (jp_clk),
    .jp_latch    (jp_latch),
    .bus         (bus.master),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int both_hi = 0;
  always @(negedge clk) if (jp_clk === 1'b1 && jp_latch === 1'b1) both_hi++;

  // ---------------- pad models (4021, active-low serial) ----------------
  logic [7:0] btn1 = 8'h00, btn2 = 8'h00;
  logic [7:0] sr1 = 8'h00, sr2 = 8'h00;

  always @(posedge jp_clk or posedge jp_latch) begin
    if (jp_latch) begin
      sr1 <= btn1;
      sr2 <= btn2;
    end else begin
      sr1 <= {1'b0, sr1[7:1]};
      sr2 <= {1'b0, sr2[7:1]};
    end
  end

  assign jp_data1 = jp_latch ? ~btn1[0] : ~sr1[0];
  assign jp_data2 = jp_latch ? ~btn2[0] : ~sr2[0];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] exp1_q[$];
  logic [7:0] exp2_q[$];
  logic [7:0] m_state1 = 8'h00, m_state2 = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // After a strobe 1->0 the CPU sees the image bits A..Right, then 1 forever.
  task automatic load_model();
    exp1_q.delete();
    exp2_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp1_q.push_back({7'b0, m_state1[i]});
      exp2_q.push_back({7'b0, m_state2[i]});
    end
  endtask

  function automatic logic [7:0] pop_exp(input logic port);
    logic [7:0] v;
    v = 8'h01;
    if (!port && exp1_q.size() > 0) v = exp1_q.pop_front();
    if (port && exp2_q.size() > 0) v = exp2_q.pop_front();
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.cs_in   = 1'b0;
    bus.a_in    = 1'b0;
    bus.r_nw_in = 1'b1;
    bus.d_in    = 8'h00;
  endtask

  task automatic cpu_write(input logic a, input logic [7:0] d);
    bus.cs_in = 1'b1; bus.a_in = a; bus.r_nw_in = 1'b0; bus.d_in = d;
    #1;
    check("wr_dout_zero", {24'b0, bus.d_out}, 0);
    step();
    bus_idle();
    #1;
  endtask

  task automatic cpu_read(input logic a, output logic [7:0] val);
    bus.cs_in = 1'b1; bus.a_in = a; bus.r_nw_in = 1'b1; bus.d_in = 8'hff;
    #1;
    val = bus.d_out;
    step();
    bus_idle();
    #1;
    check("idle_dout_zero", {24'b0, bus.d_out}, 0);
  endtask

  task automatic read_check(input string tag, input logic a);
    logic [7:0] v;
    cpu_read(a, v);
    check(tag, {24'b0, v}, {24'b0, pop_exp(a)});
  endtask

  task automatic wait_rise(output int rise);
    int k;
    k = 0;
    while (jp_latch !== 1'b1 && k < 400) begin
      step();
      k++;
    end
    check("latch_seen", {31'b0, jp_latch}, 1);
    rise = cyc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r0, r1, r2, c0, n;
    logic [7:0] v;
    bus_idle();
    nres = 1'b0;
    repeat (4) step();

    // Reset state
    check("rst_jp_clk", {31'b0, jp_clk}, 0);
    check("rst_jp_latch", {31'b0, jp_latch}, 0);
    check("rst_dbg_state", {30'b0, dbg_state}, 0);
    check("rst_dout_idle", {24'b0, bus.d_out}, 0);

    // First poll: timing of latch and clock pulses
    btn1 = 8'h09;  // A + Start
    btn2 = 8'h40;  // Left
    nres = 1'b1;
    c0 = cyc;
    wait_rise(r0);
    check("first_latch_cycle", r0 - c0, POLL_DIV);
    check("latch_dbg_state", {30'b0, dbg_state}, 1);
    n = 0;
    while (jp_latch === 1'b1 && n < 20) begin n++; step(); end
    check("latch_width", n, 2 * HALF_PERIOD);
    for (int p = 1; p <= 7; p++) begin
      n = 0;
      while (jp_clk === 1'b1 && n < 20) begin n++; step(); end
      check($sformatf("clk_hi_%0d", p), n, HALF_PERIOD);
      if (p < 7) begin
        n = 0;
        while (jp_clk === 1'b0 && n < 20) begin n++; step(); end
        check($sformatf("clk_lo_%0d", p), n, HALF_PERIOD);
      end
    end
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (jp_clk === 1'b1 || jp_latch === 1'b1) n++;
      step();
    end
    check("no_extra_pulse", n, 0);
    m_state1 = btn1;
    m_state2 = btn2;

    // Strobe 1/0 then interleaved reads; pad 2 reads leave pad 1 position alone
    cpu_write(1'b0, 8'h01);
    cpu_write(1'b0, 8'h00);
    load_model();
    for (int i = 0; i < 3; i++) read_check("rd4016_a", 1'b0);
    for (int i = 0; i < 8; i++) read_check("rd4017", 1'b1);
    for (int i = 0; i < 7; i++) read_check("rd4016_b", 1'b0);

    // Writes to $4017 do not touch strobe: reads keep shifting
    cpu_write(1'b1, 8'h01);
    read_check("rd4016_after_4017wr", 1'b0);

    // Strobe held: reads keep returning A
    cpu_write(1'b0, 8'h01);
    for (int i = 0; i < 3; i++) begin
      cpu_read(1'b0, v);
      check("strobe_hold_a", {24'b0, v}, {31'b0, m_state1[0]});
    end
    btn1 = 8'h00;
    wait_rise(r1);
    check("poll_period", r1 - r0, POLL_DIV + 16 * HALF_PERIOD + 1);
    repeat (POLL_DONE) step();
    m_state1 = btn1;
    cpu_read(1'b0, v);
    check("strobe_new_state", {24'b0, v}, {31'b0, m_state1[0]});
    cpu_read(1'b1, v);
    check("strobe_pad2_a", {24'b0, v}, {31'b0, m_state2[0]});
    cpu_write(1'b0, 8'h00);

    // Reset during CLK_HI of bit 4
    btn1 = 8'hff;
    wait_rise(r2);
    repeat (8 + 3 * 2 * HALF_PERIOD + 1) step();
    check("mid_clk_hi", {31'b0, jp_clk}, 1);
    nres = 1'b0;
    step();
    check("abort_jp_clk", {31'b0, jp_clk}, 0);
    check("abort_jp_latch", {31'b0, jp_latch}, 0);
    step();
    nres = 1'b1;
    c0 = cyc;
    m_state1 = 8'h00;
    m_state2 = 8'h00;
    cpu_read(1'b0, v);
    check("post_rst_rd4016", {24'b0, v}, 0);
    cpu_write(1'b0, 8'h01);
    cpu_write(1'b0, 8'h00);
    load_model();
    read_check("post_rst_rd4017", 1'b1);
    read_check("post_rst_rd4016", 1'b0);
    wait_rise(r2);
    check("post_rst_latch_cycle", r2 - c0, POLL_DIV);
    repeat (POLL_DONE) step();

    // Randomized pads with random-port read sequences
    for (int it = 0; it < 4; it++) begin
      btn1 = 8'($urandom_range(0, 255));
      btn2 = 8'($urandom_range(0, 255));
      wait_rise(r2);
      repeat (POLL_DONE) step();
      m_state1 = btn1;
      m_state2 = btn2;
      cpu_write(1'b0, 8'h01);
      cpu_write(1'b0, 8'h00);
      load_model();
      for (int i = 0; i < 14; i++) begin
        logic port;
        port = 1'($urandom_range(0, 1));
        read_check(port ? "rand_rd4017" : "rand_rd4016", port);
      end
    end

    check("never_both_high", both_hi, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
